uart_tx_serializer: RTL

UART transmit serializer. Consumes the transmit flag/data registers written by the CPU through the UART memory-mapped register block and shifts the byte out on the serial line as an 8N1 frame (optionally 8E1). Sits directly downstream of that register block: bit 0 of its transmit-flag register drives `tx_start`, and the low byte of its transmit-data register drives `tx_data`. The busy and done outputs feed back so software can poll completion and clear the flag.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_serializer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_pkg                                                      |
// | Purpose  : Shared UART definitions: frame state encoding, data width,    |
// |            default bit timing and a parity helper. Shared by the         |
// |            transmitter and the planned receiver.                         |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = UART_ST_IDLE,
    ST_START  = UART_ST_START,
    ST_DATA   = UART_ST_DATA,
    ST_PARITY = UART_ST_PARITY,
    ST_STOP   = UART_ST_STOP
  } uart_state_e;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_baud_gen                                                 |
// | Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps;       |
// |            a synchronous clear restarts the period (used on state entry).|
// | Ports    : clk      - clock, rising edge                                 |
// |            rst      - asynchronous active-high reset                     |
// |            clear_i  - synchronous clear to 0                             |
// |            count_o  - current position within the bit period            |
// |            tick_o   - high on the last cycle of the bit period           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] count_q;

  assign tick_o  = (count_q == CNT_W'(CLKS_PER_BIT - 1));
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_serializer                                            |
// | Purpose  : UART transmitter. Detects rising edges of the transmit flag,  |
// |            holds one pending request and shifts the byte out as an 8N1  |
// |            frame (8E1 when UART_TX_PARITY_EN is defined), LSB first.     |
// | Macro    : UART_TX_PARITY_EN - adds an even-parity bit after the data.   |
// | Ports    : clk       - clock, rising edge                                |
// |            rst       - asynchronous active-high reset                    |
// |            tx_start  - transmit request level (edge triggered)           |
// |            tx_data   - byte to send, sampled when the frame is accepted  |
// |            tx        - serial line, idle high (registered)               |
// |            tx_busy   - high from first start-bit cycle to last stop cycle|
// |            tx_done   - one-cycle pulse on the last stop-bit cycle        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  uart_state_e               state_q, state_d;
  logic                      tx_start_dly_q;
  logic                      pending_q, pending_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic [CNT_W-1:0]          baud_cnt;
  logic                      baud_tick;
  logic                      baud_clear;
  logic                      start_edge;
  logic                      accept;

  // Bit timer; held at zero in IDLE and restarted whenever the state changes
  // so every state lasts exactly CLKS_PER_BIT cycles.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear_i (baud_clear),
    .count_o (baud_cnt),
    .tick_o  (baud_tick)
  );

  assign baud_clear = (state_d != state_q) || (state_q == ST_IDLE);

  // The delayed copy resets low, so a level already high when reset is
  // released is seen as a fresh request.
  assign start_edge = tx_start & ~tx_start_dly_q;

  // One-deep request: extra edges while a request is pending are absorbed.
  assign pending_d = (pending_q & ~accept) | start_edge;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    accept    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          accept    = 1'b1;
          shift_d   = tx_data;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = uart_even_parity(tx_data);
`endif
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // together with the state register and have no path from the inputs.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    // The counter reaches CLKS_PER_BIT-1 on the cycle after CLKS_PER_BIT-2,
    // so registering this lines the pulse up with the last stop cycle.
    done_d = (state_q == ST_STOP) && (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tx_start_dly_q <= 1'b0;
      pending_q      <= 1'b0;
      shift_q        <= '0;
      bit_idx_q      <= '0;
      tx_q           <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tx_start_dly_q <= tx_start;
      pending_q      <= pending_d;
      shift_q        <= shift_d;
      bit_idx_q      <= bit_idx_d;
      tx_q           <= tx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire
